// File: rtl/matrix_mem_pkg.sv
// Shared types and default sizing for the matrix memory responder.
// The optional range check is enabled with the macro MATRIX_MEM_BOUNDS_CHECK_EN.
package matrix_mem_pkg;

  localparam int DEF_ADDR_WIDTH = 15;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_DEPTH      = 4096;
  localparam int DEF_LATENCY    = 2;

  // Wide enough for the largest legal LATENCY (15)
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    DONE    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/matrix_memory_responder_if.sv
// Initiator <-> responder request/response bundle for the matrix memory responder.
interface matrix_memory_responder_if
  import matrix_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();

  logic                  memory_enable;
  logic                  memory_readWrite;
  logic [ADDR_WIDTH-1:0] memory_address;
  logic [DATA_WIDTH-1:0] memory_data_write;
  logic [DATA_WIDTH-1:0] memory_data_read;
  logic                  memory_done;
  logic                  memory_error;

  modport master (
    output memory_enable, memory_readWrite, memory_address, memory_data_write,
    input  memory_data_read, memory_done, memory_error
  );

  modport slave (
    input  memory_enable, memory_readWrite, memory_address, memory_data_write,
    output memory_data_read, memory_done, memory_error
  );

endinterface

// File: rtl/matrix_mem_array.sv
// Single-port synchronous RAM; the read register holds its value until the next read.
module matrix_mem_array #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4096,
  parameter int IDX_W      = 12
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_we,
  input  logic                  i_re,
  input  logic                  i_rd_ones,
  input  logic [IDX_W-1:0]      i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  // Array contents survive reset; only the read register is cleared
  always_ff @(posedge clock) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  always_ff @(posedge clock) begin
    if (reset)     r_rdata <= '0;
    else if (i_re) r_rdata <= i_rd_ones ? '1 : r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/matrix_memory_responder.sv
// Fixed-latency memory responder: accept, count, one-cycle done, wait for enable release.
// Optional address range check enabled by macro MATRIX_MEM_BOUNDS_CHECK_EN.
module matrix_memory_responder
  import matrix_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int LATENCY    = DEF_LATENCY
) (
  input  logic                       clock,
  input  logic                       reset,
  matrix_memory_responder_if.slave   bus
);

  localparam int             IDX_W    = idx_width(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_rw;
  logic [IDX_W-1:0]      r_idx;
  logic [DATA_WIDTH-1:0] r_wdata;

  logic                  w_accept;
  logic                  w_last;
  logic                  w_oor;
  logic                  w_done;
  logic                  w_we;
  logic                  w_re;
  logic [DATA_WIDTH-1:0] w_rdata;

  assign w_accept = (r_state == IDLE) && bus.memory_enable;
  assign w_last   = (r_cnt == CNT_LAST);

`ifdef MATRIX_MEM_BOUNDS_CHECK_EN
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);
  logic r_oor;

  always_ff @(posedge clock) begin
    if (w_accept) r_oor <= ({1'b0, bus.memory_address} >= DEPTH_L);
  end

  assign w_oor = r_oor;
`else
  assign w_oor = 1'b0;
`endif

  // State register and latency counter
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept)                          r_cnt <= '0;
      else if (r_state == ACCESS && !w_last) r_cnt <= r_cnt + 1'b1;
    end
  end

  // Request fields are frozen at accept; later input changes are ignored
  always_ff @(posedge clock) begin
    if (w_accept) begin
      r_rw    <= bus.memory_readWrite;
      r_idx   <= bus.memory_address[IDX_W-1:0];
      r_wdata <= bus.memory_data_write;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.memory_enable)  w_state_nxt = ACCESS;
      ACCESS:  if (w_last)             w_state_nxt = DONE;
      DONE:                            w_state_nxt = RELEASE;
      RELEASE: if (!bus.memory_enable) w_state_nxt = IDLE;
      default:                         w_state_nxt = IDLE;
    endcase
  end

  // Read is launched in the last ACCESS cycle so the RAM register is valid in DONE
  always_comb begin
    w_done = 1'b0;
    w_we   = 1'b0;
    w_re   = 1'b0;
    case (r_state)
      ACCESS: w_re = r_rw && w_last;
      DONE: begin
        w_done = 1'b1;
        w_we   = !r_rw && !w_oor;
      end
      default: ;
    endcase
  end

  matrix_mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .IDX_W      (IDX_W)
  ) u_array (
    .clock     (clock),
    .reset     (reset),
    .i_we      (w_we),
    .i_re      (w_re),
    .i_rd_ones (w_oor),
    .i_addr    (r_idx),
    .i_wdata   (r_wdata),
    .o_rdata   (w_rdata)
  );

  assign bus.memory_done      = w_done;
  assign bus.memory_error     = w_done & w_oor;
  assign bus.memory_data_read = w_rdata;

endmodule

// File: tb/tb_matrix_memory_responder.sv
// Directed plus randomized bench for matrix_memory_responder against a word-array model.
module tb_matrix_memory_responder;

  localparam int AW    = 15;
  localparam int DW    = 32;
  localparam int DEPTH = 4096;
  localparam int LAT   = 2;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  matrix_memory_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  matrix_memory_responder #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .LATENCY    (LAT)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int              n_checks = 0;
  int              n_err    = 0;
  logic [DW-1:0]   mem_m [int];
  logic [DW-1:0]   last_rd    = '0;
  bit              last_known = 1'b1;
  logic [AW-1:0]   wq [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit oor(input logic [AW-1:0] a);
`ifdef MATRIX_MEM_BOUNDS_CHECK_EN
    return int'(a) >= DEPTH;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int slot(input logic [AW-1:0] a);
    return int'(a) % DEPTH;
  endfunction

  // One complete transaction; enable stays high for LAT+hold cycles after accept
  task automatic txn(input string tag, input bit rw, input logic [AW-1:0] addr,
                     input logic [DW-1:0] wd, input int hold, input logic [AW-1:0] scr_addr);
    int            done_at;
    int            n_done;
    logic [DW-1:0] got_d;
    logic          got_e;
    logic [DW-1:0] exp_d;
    bit            exp_e;
    bit            known;
    exp_e = oor(addr);
    known = 1'b1;
    exp_d = '0;
    if (rw) begin
      if (exp_e)                          exp_d = '1;
      else if (mem_m.exists(slot(addr)))  exp_d = mem_m[slot(addr)];
      else                                known = 1'b0;
    end
    @(negedge clock);
    bus.memory_enable     = 1'b1;
    bus.memory_readWrite  = rw;
    bus.memory_address    = addr;
    bus.memory_data_write = wd;
    @(posedge clock); #1;
    bus.memory_address    = scr_addr;
    bus.memory_data_write = ~wd;
    bus.memory_readWrite  = ~rw;
    done_at = -1;
    n_done  = 0;
    got_d   = 'x;
    got_e   = 1'bx;
    for (int c = 1; c <= LAT + hold; c++) begin
      @(posedge clock); #1;
      if (bus.memory_done === 1'b1) begin
        n_done++;
        if (done_at < 0) begin
          done_at = c;
          got_d   = bus.memory_data_read;
          got_e   = bus.memory_error;
        end
      end
    end
    bus.memory_enable = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clock); #1;
      if (bus.memory_done === 1'b1) n_done++;
    end
    if (rw) begin
      last_rd    = exp_d;
      last_known = known;
    end else if (!exp_e) begin
      mem_m[slot(addr)] = wd;
    end
    chk({tag, ".lat"},    64'(done_at), 64'(LAT));
    chk({tag, ".pulses"}, 64'(n_done), 64'd1);
    chk({tag, ".err"},    64'(got_e), 64'(exp_e));
    if (rw && known) chk({tag, ".rdata"}, 64'(got_d), 64'(exp_d));
    if (last_known)  chk({tag, ".hold"}, 64'(bus.memory_data_read), 64'(last_rd));
  endtask

  initial begin
    int            n_done;
    logic [AW-1:0] a;
    bit            rw;

    reset                 = 1'b1;
    bus.memory_enable     = 1'b0;
    bus.memory_readWrite  = 1'b0;
    bus.memory_address    = '0;
    bus.memory_data_write = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst.done",  64'(bus.memory_done), 64'd0);
    chk("rst.err",   64'(bus.memory_error), 64'd0);
    chk("rst.rdata", 64'(bus.memory_data_read), 64'd0);
    @(negedge clock);
    reset = 1'b0;

    txn("w_cafe", 1'b0, 15'h0010, 32'hCAFE0001, 2, 15'h0077);
    txn("r_cafe", 1'b1, 15'h0010, 32'h0, 10, 15'h0078);

    txn("pre5", 1'b0, 15'h0005, 32'h11111111, 2, 15'h0005);
    @(negedge clock);
    bus.memory_enable     = 1'b1;
    bus.memory_readWrite  = 1'b0;
    bus.memory_address    = 15'h0005;
    bus.memory_data_write = 32'h12345678;
    @(posedge clock);
    @(negedge clock);
    reset  = 1'b1;
    n_done = 0;
    @(posedge clock); #1;
    if (bus.memory_done === 1'b1) n_done++;
    @(negedge clock);
    reset             = 1'b0;
    bus.memory_enable = 1'b0;
    for (int c = 0; c < LAT + 3; c++) begin
      @(posedge clock); #1;
      if (bus.memory_done === 1'b1) n_done++;
    end
    chk("abort.nodone", 64'(n_done), 64'd0);
    chk("abort.rdata",  64'(bus.memory_data_read), 64'd0);
    last_rd    = '0;
    last_known = 1'b1;
    txn("abort.rd5", 1'b1, 15'h0005, 32'h0, 2, 15'h0006);

    txn("pre21", 1'b0, 15'h0021, 32'h0BADF00D, 2, 15'h0021);
    txn("w20",   1'b0, 15'h0020, 32'h00000011, 3, 15'h0021);
    txn("r20",   1'b1, 15'h0020, 32'h0, 2, 15'h0021);
    txn("r21",   1'b1, 15'h0021, 32'h0, 2, 15'h0020);

`ifdef MATRIX_MEM_BOUNDS_CHECK_EN
    txn("w0",     1'b0, 15'h0000, 32'h5A5A0000, 2, 15'h1000);
    txn("r1000",  1'b1, 15'h1000, 32'h0, 2, 15'h0000);
    txn("w1000",  1'b0, 15'h1000, 32'hDEADBEEF, 2, 15'h0000);
    txn("r0",     1'b1, 15'h0000, 32'h0, 2, 15'h1000);
`else
    txn("w1003",  1'b0, 15'h1003, 32'hA5A5A5A5, 2, 15'h0003);
    txn("r0003",  1'b1, 15'h0003, 32'h0, 2, 15'h1003);
`endif

    for (int i = 0; i < 24; i++) begin
      rw = (wq.size() == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      if (rw) begin
        a = wq[$urandom_range(0, wq.size() - 1)];
        if ($urandom_range(0, 1) == 1) a = {3'($urandom), a[11:0]};
        txn("rnd_r", 1'b1, a, 32'h0, $urandom_range(2, 5), 15'($urandom));
      end else begin
        a = 15'($urandom);
        wq.push_back(a);
        txn("rnd_w", 1'b0, a, $urandom, $urandom_range(2, 5), 15'($urandom));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
